sample_rate_gen: RTL

//  Phase-accumulator (NCO) sample-rate strobe generator with runtime-selectable rate.

---
 rtl/sample_rate_gen.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sample_rate_gen.sv
// Phase-accumulator sample-rate strobe generator: fractional os_tick / sample_tick
// strobes from clk, runtime rate selection with a glitch-free handshake, running index.
module sample_rate_gen #(
    parameter int ACC_W = 32,
    parameter int OS    = 4,
    parameter int IDX_W = 24,
    parameter logic [ACC_W-1:0] INC0 = ACC_W'(7576322),
    parameter logic [ACC_W-1:0] INC1 = ACC_W'(8246337),
    parameter logic [ACC_W-1:0] INC2 = ACC_W'(3788161)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             idx_clr,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       rate_sel,
    input  logic [ACC_W-1:0] custom_inc,
    output logic [1:0]       cur_rate,
    output logic             os_tick,
    output logic             sample_tick,
    output logic [IDX_W-1:0] sample_idx
);
    // state | meaning
    // IDLE  | generator stopped, phase and os count held at zero
    // RUN   | accumulator advancing, strobes generated on wrap
    typedef enum logic {IDLE, RUN} state_t;

    localparam int OS_W = (OS > 1) ? $clog2(OS) : 1;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [OS_W-1:0]  os_cnt;
    logic             pending;
    logic [ACC_W-1:0] pend_inc;
    logic [1:0]       pend_rate;

    logic [ACC_W-1:0] sel_inc;
    logic [ACC_W:0]   sum;
    logic             accept;
    logic             os_last;

    always_comb begin
        sel_inc = custom_inc;
        case (rate_sel)
            2'd0:    sel_inc = INC0;
            2'd1:    sel_inc = INC1;
            2'd2:    sel_inc = INC2;
            default: sel_inc = custom_inc;
        endcase
    end

    assign sum       = {1'b0, acc} + {1'b0, inc};
    assign os_last   = (os_cnt == OS_W'(OS - 1));
    assign accept    = cfg_valid && !pending;
    assign cfg_ready = !pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            inc         <= INC0;
            os_cnt      <= '0;
            os_tick     <= 1'b0;
            sample_tick <= 1'b0;
            cur_rate    <= 2'd0;
            sample_idx  <= '0;
            pending     <= 1'b0;
            pend_inc    <= '0;
            pend_rate   <= 2'd0;
        end else begin
            // Index counts the strobe visible this cycle, so a clear in that cycle wins.
            if (idx_clr)
                sample_idx <= '0;
            else if (sample_tick)
                sample_idx <= sample_idx + 1'b1;

            case (state)
                IDLE: begin
                    acc         <= '0;
                    os_cnt      <= '0;
                    os_tick     <= 1'b0;
                    sample_tick <= 1'b0;
                    if (accept) begin
                        inc      <= sel_inc;
                        cur_rate <= rate_sel;
                    end
                    if (enable)
                        state <= RUN;
                end
                RUN: begin
                    if (!enable) begin
                        state       <= IDLE;
                        acc         <= '0;
                        os_cnt      <= '0;
                        os_tick     <= 1'b0;
                        sample_tick <= 1'b0;
                        if (pending) begin
                            inc      <= pend_inc;
                            cur_rate <= pend_rate;
                            pending  <= 1'b0;
                        end else if (accept) begin
                            inc      <= sel_inc;
                            cur_rate <= rate_sel;
                        end
                    end else begin
                        acc         <= sum[ACC_W-1:0];
                        os_tick     <= sum[ACC_W];
                        sample_tick <= sum[ACC_W] && os_last;
                        if (sum[ACC_W])
                            os_cnt <= os_last ? '0 : os_cnt + 1'b1;
                        // Rate swaps only on a sample boundary so phase stays continuous.
                        if (pending && sample_tick) begin
                            inc      <= pend_inc;
                            cur_rate <= pend_rate;
                            pending  <= 1'b0;
                        end else if (accept) begin
                            pending   <= 1'b1;
                            pend_inc  <= sel_inc;
                            pend_rate <= rate_sel;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
